spi_frame_parser: RTL

Sits directly downstream of the SPI slave byte receiver. It consumes that receiver's byte stream (`done` level plus `dout` byte) and assembles framed commands of the form SYNC, CMD, LEN, payload[LEN], CHK. Payload is buffered internally and released as a valid/ready byte stream only after the checksum passes. Frames with bad checksum, bad length or an SPI abort are discarded and flagged.

---
 rtl/spi_frame_pkg.sv | 21 ++
 rtl/spi_frame_buf.sv | 24 ++
 rtl/spi_frame_parser.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types and defaults for the SPI frame parser.
// Holds the parser state encoding and the running-checksum helper.
package spi_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_t;

    localparam int         DEF_MAX_LEN   = 16;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] xor8(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/spi_frame_buf.sv
// Payload store: one write port, one registered read port, storage not reset.
// Read data appears one cycle after the address is presented.
module spi_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_dat,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_dat
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        o_rd_dat <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/spi_frame_parser.sv
// Assembles SYNC/CMD/LEN/payload/CHK frames from the SPI byte receiver and
// releases the payload as a valid/ready stream only once the checksum passes.
module spi_frame_parser
    import spi_frame_pkg::*;
#(
    parameter int         MAX_LEN   = DEF_MAX_LEN,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_done,
    input  logic [7:0] byte_data,
    input  logic       ss,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frm_ok,
    output logic [7:0] frm_cmd,
    output logic [7:0] frm_len,
    output logic       chk_err,
    output logic       len_err,
    output logic       abort_err,
    output logic       ovf_err,
    output logic       busy
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t        r_state, w_state_nxt;
    logic          r_done_q;
    logic [7:0]    r_cmd, w_cmd_nxt;
    logic [7:0]    r_len, w_len_nxt;
    logic [7:0]    r_chk, w_chk_nxt;
    logic [AW-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [AW-1:0] r_rd_ptr, w_rd_ptr_nxt;
    logic [7:0]    r_frm_cmd, w_frm_cmd_nxt;
    logic [7:0]    r_frm_len, w_frm_len_nxt;
    logic          r_frm_ok, w_frm_ok_nxt;
    logic          r_chk_err, w_chk_err_nxt;
    logic          r_len_err, w_len_err_nxt;
    logic          r_abort_err, w_abort_err_nxt;
    logic          r_ovf_err, w_ovf_err_nxt;

    logic          w_stb;
    logic          w_drain;
    logic          w_accept;
    logic          w_rd_last;
    logic          w_wr_en;
    logic [7:0]    w_rd_dat;

    assign w_stb     = byte_done & ~r_done_q;
    assign w_drain   = (r_state == ST_DRAIN);
    assign w_accept  = w_drain & out_ready;
    assign w_rd_last = (8'(r_rd_ptr) == (r_len - 8'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HUNT;
            r_done_q    <= 1'b0;
            r_cmd       <= '0;
            r_len       <= '0;
            r_chk       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_frm_cmd   <= '0;
            r_frm_len   <= '0;
            r_frm_ok    <= 1'b0;
            r_chk_err   <= 1'b0;
            r_len_err   <= 1'b0;
            r_abort_err <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_done_q    <= byte_done;
            r_cmd       <= w_cmd_nxt;
            r_len       <= w_len_nxt;
            r_chk       <= w_chk_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_frm_cmd   <= w_frm_cmd_nxt;
            r_frm_len   <= w_frm_len_nxt;
            r_frm_ok    <= w_frm_ok_nxt;
            r_chk_err   <= w_chk_err_nxt;
            r_len_err   <= w_len_err_nxt;
            r_abort_err <= w_abort_err_nxt;
            r_ovf_err   <= w_ovf_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_len_nxt       = r_len;
        w_chk_nxt       = r_chk;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = '0;
        w_frm_cmd_nxt   = r_frm_cmd;
        w_frm_len_nxt   = r_frm_len;
        w_frm_ok_nxt    = 1'b0;
        w_chk_err_nxt   = 1'b0;
        w_len_err_nxt   = 1'b0;
        w_abort_err_nxt = 1'b0;
        w_ovf_err_nxt   = 1'b0;
        w_wr_en         = 1'b0;

        case (r_state)
            ST_HUNT: begin
                if (w_stb && (byte_data == SYNC_BYTE)) begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (ss) begin
                    w_abort_err_nxt = 1'b1;
                    w_state_nxt     = ST_HUNT;
                end else if (w_stb) begin
                    w_cmd_nxt   = byte_data;
                    w_chk_nxt   = byte_data;
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (ss) begin
                    w_abort_err_nxt = 1'b1;
                    w_state_nxt     = ST_HUNT;
                end else if (w_stb) begin
                    w_chk_nxt = xor8(r_chk, byte_data);
                    if (byte_data > MAX_LEN_B) begin
                        w_len_err_nxt = 1'b1;
                        w_state_nxt   = ST_HUNT;
                    end else if (byte_data == 8'd0) begin
                        w_len_nxt   = 8'd0;
                        w_state_nxt = ST_CHK;
                    end else begin
                        w_len_nxt    = byte_data;
                        w_wr_ptr_nxt = '0;
                        w_state_nxt  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (ss) begin
                    w_abort_err_nxt = 1'b1;
                    w_state_nxt     = ST_HUNT;
                end else if (w_stb) begin
                    w_wr_en   = 1'b1;
                    w_chk_nxt = xor8(r_chk, byte_data);
                    if (8'(r_wr_ptr) == (r_len - 8'd1)) begin
                        w_state_nxt = ST_CHK;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
                    end
                end
            end
            ST_CHK: begin
                // rd_ptr defaults to 0 here, so the first payload byte is
                // already in the read register when DRAIN is entered.
                if (ss) begin
                    w_abort_err_nxt = 1'b1;
                    w_state_nxt     = ST_HUNT;
                end else if (w_stb) begin
                    if (byte_data == r_chk) begin
                        w_frm_ok_nxt  = 1'b1;
                        w_frm_cmd_nxt = r_cmd;
                        w_frm_len_nxt = r_len;
                        w_state_nxt   = (r_len != 8'd0) ? ST_DRAIN : ST_HUNT;
                    end else begin
                        w_chk_err_nxt = 1'b1;
                        w_state_nxt   = ST_HUNT;
                    end
                end
            end
            ST_DRAIN: begin
                w_rd_ptr_nxt  = r_rd_ptr;
                w_ovf_err_nxt = w_stb;
                if (w_accept) begin
                    if (w_rd_last) begin
                        w_rd_ptr_nxt = '0;
                        w_state_nxt  = ST_HUNT;
                    end else begin
                        w_rd_ptr_nxt = r_rd_ptr + AW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    // Read address follows the next pointer so the read register tracks
    // rd_ptr with no bubble and holds its value while stalled.
    spi_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (byte_data),
        .i_rd_addr (w_rd_ptr_nxt),
        .o_rd_dat  (w_rd_dat)
    );

    assign out_valid = w_drain;
    assign out_data  = w_drain ? w_rd_dat : 8'd0;
    assign out_last  = w_drain & w_rd_last;
    assign frm_ok    = r_frm_ok;
    assign frm_cmd   = r_frm_cmd;
    assign frm_len   = r_frm_len;
    assign chk_err   = r_chk_err;
    assign len_err   = r_len_err;
    assign abort_err = r_abort_err;
    assign ovf_err   = r_ovf_err;
    assign busy      = (r_state != ST_HUNT);

endmodule
